col_sen_emu: RTL

- Synthesizable emulator of the TCS3200-style colour sensor, i.e. the sensor end of the s2/s3 filter-select + colour_freq interface.
- Samples the filter-select (s2, s3) and scaling (s0, s1) pins and drives a square wave whose half-period is programmed per filter.
- Used for hardware-in-loop bring-up of the colour-classification logic without a physical sensor.

---
 rtl/col_sen_pkg.sv | 43 ++++
 rtl/col_sen_sqgen.sv | 66 ++++++
 rtl/col_sen_emu.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/col_sen_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// col_sen_pkg : shared codes and helpers for the colour sensor emulator
// rev 1.0
// ------------------------------------------------------------------
package col_sen_pkg;

  localparam logic [1:0] FLT_RED   = 2'b00;
  localparam logic [1:0] FLT_BLUE  = 2'b01;
  localparam logic [1:0] FLT_CLEAR = 2'b10;
  localparam logic [1:0] FLT_GREEN = 2'b11;

  // Scaling pin codes {s0,s1}; 00 powers the sensor down.
  localparam logic [1:0] SCL_OFF  = 2'b00;
  localparam logic [1:0] SCL_2    = 2'b01;
  localparam logic [1:0] SCL_20   = 2'b10;
  localparam logic [1:0] SCL_100  = 2'b11;

  localparam int unsigned SCL_K100 = 1;
  localparam int unsigned SCL_K20  = 5;
  localparam int unsigned SCL_K2   = 50;

  localparam int PRE_W = 6;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  function automatic logic [PRE_W-1:0] scale_k(input logic [1:0] scl);
    logic [PRE_W-1:0] k;
    case (scl)
      SCL_100: k = PRE_W'(SCL_K100);
      SCL_20:  k = PRE_W'(SCL_K20);
      SCL_2:   k = PRE_W'(SCL_K2);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/col_sen_sqgen.sv
`default_nettype none
// ------------------------------------------------------------------
// col_sen_sqgen : prescaled half-period counter and square-wave toggle
// rev 1.0
// ------------------------------------------------------------------
module col_sen_sqgen
  import col_sen_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic [PRE_W-1:0] k_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             wave_o,
  output logic             rise_o
);

  logic [PRE_W-1:0] pre_q;
  logic [CNT_W-1:0] hcnt_q;
  logic             wave_q;
  logic             rise_q;

  logic [CNT_W-1:0] half_m1;
  logic             pre_wrap;
  logic             half_done;

  // A programmed half of zero behaves as one; >= lets a shrunk half toggle at once.
  assign half_m1   = (half_i == '0) ? '0 : half_i - CNT_W'(1);
  assign pre_wrap  = (pre_q == k_i - PRE_W'(1));
  assign half_done = (hcnt_q >= half_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      hcnt_q <= '0;
      wave_q <= 1'b0;
      rise_q <= 1'b0;
    end else if (clear_i) begin
      pre_q  <= '0;
      hcnt_q <= '0;
      wave_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      if (pre_wrap) begin
        pre_q <= '0;
        if (half_done) begin
          hcnt_q <= '0;
          wave_q <= ~wave_q;
          rise_q <= ~wave_q;
        end else begin
          hcnt_q <= hcnt_q + CNT_W'(1);
        end
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
    end
  end

  assign wave_o = wave_q;
  assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/col_sen_emu.sv
`default_nettype none
// ------------------------------------------------------------------
// col_sen_emu : TCS3200-style colour sensor emulator (filter/scale pins in, frequency out)
// rev 1.0
// ------------------------------------------------------------------
module col_sen_emu
  import col_sen_pkg::*;
#(
  parameter int          CNT_W      = 20,
  parameter int          SETTLE_CYC = 16,
  parameter int unsigned HALF_RED   = 1350,
  parameter int unsigned HALF_BLUE  = 2000,
  parameter int unsigned HALF_CLEAR = 800,
  parameter int unsigned HALF_GREEN = 6700
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             s3,
  input  logic             oe_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             colour_freq,
  output logic             period_pulse
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  logic [1:0]       sel_q, scl_q;
  logic [1:0]       sel_prev_q, scl_prev_q;
  logic [CNT_W-1:0] half_q [4];
  state_e           state_q;
  logic [SW-1:0]    settle_q;
  logic             cfg_ready_q;
  logic             colour_freq_q;

  logic             chg;
  logic             sq_clear;
  logic             wave;
  logic             rise;
  logic             colour_freq_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      scl_q      <= '0;
      sel_prev_q <= '0;
      scl_prev_q <= '0;
    end else begin
      sel_q      <= {s2, s3};
      scl_q      <= {s0, s1};
      sel_prev_q <= sel_q;
      scl_prev_q <= scl_q;
    end
  end

  assign chg = (sel_q != sel_prev_q) || (scl_q != scl_prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q[FLT_RED]   <= CNT_W'(HALF_RED);
      half_q[FLT_BLUE]  <= CNT_W'(HALF_BLUE);
      half_q[FLT_CLEAR] <= CNT_W'(HALF_CLEAR);
      half_q[FLT_GREEN] <= CNT_W'(HALF_GREEN);
    end else if (cfg_valid && cfg_ready_q) begin
      half_q[cfg_sel] <= cfg_half;
    end
  end

  // Power-down overrides every state; otherwise any pin change restarts settling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      settle_q    <= '0;
      cfg_ready_q <= 1'b0;
    end else if (scl_q == SCL_OFF) begin
      state_q     <= ST_OFF;
      settle_q    <= '0;
      cfg_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_q     <= ST_SETTLE;
          settle_q    <= '0;
          cfg_ready_q <= 1'b0;
        end
        ST_SETTLE: begin
          if (chg) begin
            settle_q <= '0;
          end else if (settle_q == SETTLE_LAST) begin
            state_q     <= ST_RUN;
            settle_q    <= '0;
            cfg_ready_q <= 1'b1;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        ST_RUN: begin
          if (chg) begin
            state_q     <= ST_SETTLE;
            settle_q    <= '0;
            cfg_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_OFF;
          settle_q    <= '0;
          cfg_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // A change wins over a toggle landing in the same cycle.
  assign sq_clear = (state_q != ST_RUN) || chg || (scl_q == SCL_OFF);

  col_sen_sqgen #(
    .CNT_W (CNT_W)
  ) u_sqgen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (sq_clear),
    .k_i     (scale_k(scl_q)),
    .half_i  (half_q[sel_q]),
    .wave_o  (wave),
    .rise_o  (rise)
  );

  assign colour_freq_d = wave & ~oe_n & ~sq_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_freq_q <= 1'b0;
    end else begin
      colour_freq_q <= colour_freq_d;
    end
  end

  assign colour_freq  = colour_freq_q;
  assign period_pulse = rise;
  assign cfg_ready    = cfg_ready_q;

endmodule
`default_nettype wire
